// File: rtl/umi_arb_pkg.sv
// Shared types and helpers for the UMI round-robin arbiter.
// Holds the FSM state type, the default end-of-message bit position and
// the round-robin pointer advance helper.
package umi_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Position of the end-of-message flag inside a UMI command word.
  localparam int UMI_EOM_BIT = 22;

  // Next round-robin start position: the slot after ptr, wrapping at n.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/umi_arb_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request
// starting at ptr and scanning upward with wrap-around. Returns the winner
// as a one-hot vector and as an index, plus a flag saying anyone won.
module umi_arb_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest offset down to offset 0 so the closest request
  // to ptr is the last one written and therefore wins.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end

  // One-hot form of the winning index.
  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = any && (idx == IW'(gi));
  end

endmodule

// File: rtl/umi_rr_arbiter.sv
// N-input round-robin arbiter sharing one UMI valid/ready stream.
// Grants are packet-atomic: a multi-beat transaction keeps the grant until
// the beat carrying cmd[EOM_BIT]. The output is a single register stage
// that can be reloaded in the same cycle it is drained (1 beat/cycle).
// Optional feature: define UMI_RR_ARBITER_STATS_EN to add the stat_beats
// port with a 32-bit accepted-beat counter per requester.
module umi_rr_arbiter
  import umi_arb_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int CW      = 32,
  parameter  int AW      = 64,
  parameter  int DW      = 256,
  parameter  int EOM_BIT = UMI_EOM_BIT,
  localparam int IW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready,
  output logic [IW-1:0]   umi_out_srcid
`ifdef UMI_RR_ARBITER_STATS_EN
  ,
  output logic [N*32-1:0] stat_beats
`endif
);

  // Unpacked views of the flattened request buses.
  logic [CW-1:0] in_cmd [N];
  logic [AW-1:0] in_dst [N];
  logic [AW-1:0] in_src [N];
  logic [DW-1:0] in_data[N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign in_cmd[gi]  = umi_in_cmd[gi*CW +: CW];
    assign in_dst[gi]  = umi_in_dstaddr[gi*AW +: AW];
    assign in_src[gi]  = umi_in_srcaddr[gi*AW +: AW];
    assign in_data[gi] = umi_in_data[gi*DW +: DW];
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] lock_q, lock_d;

  logic          out_valid_q;
  logic [CW-1:0] out_cmd_q;
  logic [AW-1:0] out_dst_q;
  logic [AW-1:0] out_src_q;
  logic [DW-1:0] out_data_q;
  logic [IW-1:0] out_srcid_q;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  logic [N-1:0]  grant;
  logic [IW-1:0] gidx;
  logic          gany;
  logic          load;
  logic          accept;
  logic          sel_eom;

  umi_arb_rr_pick #(.N(N)) u_pick (
    .req (umi_in_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The output register may take a new beat when empty or being drained.
  assign load = !out_valid_q || umi_out_ready;

  // While locked only the lock holder can be granted, and only when it is
  // presenting a beat; nobody else may slip in between packet beats.
  always_comb begin
    grant = '0;
    gidx  = pick_idx;
    gany  = pick_any;
    if (state_q == ARB_LOCKED) begin
      gidx         = lock_q;
      gany         = umi_in_valid[lock_q];
      grant[lock_q] = umi_in_valid[lock_q];
    end else begin
      grant = pick_gnt;
    end
  end

  assign umi_in_ready = (load && nreset) ? grant : '0;
  assign accept       = load && gany && nreset;
  assign sel_eom      = in_cmd[gidx][EOM_BIT];

  // Packet lock FSM and round-robin pointer; the pointer moves only when a
  // new transaction starts so a locked packet never shifts fairness.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    if (accept) begin
      if (state_q == ARB_IDLE) begin
        rr_ptr_d = IW'(rr_next(int'(gidx), N));
        if (!sel_eom) begin
          state_d = ARB_LOCKED;
          lock_d  = gidx;
        end
      end else if (sel_eom) begin
        state_d = ARB_IDLE;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
    end
  end

  // Output pipeline stage: capture the granted beat on load, hold otherwise.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      out_srcid_q <= '0;
    end else if (load) begin
      out_valid_q <= accept;
      if (accept) begin
        out_cmd_q   <= in_cmd[gidx];
        out_dst_q   <= in_dst[gidx];
        out_src_q   <= in_src[gidx];
        out_data_q  <= in_data[gidx];
        out_srcid_q <= gidx;
      end
    end
  end

  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_cmd_q;
  assign umi_out_dstaddr = out_dst_q;
  assign umi_out_srcaddr = out_src_q;
  assign umi_out_data    = out_data_q;
  assign umi_out_srcid   = out_srcid_q;

`ifdef UMI_RR_ARBITER_STATS_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_stats
    logic [31:0] beats_q;

    // Count every beat accepted from this requester; wraps naturally.
    always_ff @(posedge clk) begin
      if (!nreset) begin
        beats_q <= '0;
      end else if (umi_in_ready[gi] && umi_in_valid[gi]) begin
        beats_q <= beats_q + 32'd1;
      end
    end

    assign stat_beats[gi*32 +: 32] = beats_q;
  end
`endif

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Directed testbench for umi_rr_arbiter (N=4): reset/idle, round-robin
// rotation, packet locking, backpressure, reset mid-packet and, when
// UMI_RR_ARBITER_STATS_EN is defined, the beat counters.
module tb_umi_rr_arbiter;
  import umi_arb_pkg::*;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;
  logic [1:0]      umi_out_srcid;
`ifdef UMI_RR_ARBITER_STATS_EN
  logic [N*32-1:0] stat_beats;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  umi_rr_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .EOM_BIT(22)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .umi_out_srcid   (umi_out_srcid)
`ifdef UMI_RR_ARBITER_STATS_EN
    ,
    .stat_beats      (stat_beats)
`endif
  );

  // Per-requester, per-tag unique beat contents.
  function automatic logic [31:0] mk_cmd(input int r, input int tag, input logic eom);
    logic [31:0] c;
    c     = 32'((tag << 8) | r);
    c[22] = eom;
    return c;
  endfunction

  function automatic logic [63:0] mk_dst(input int r, input int tag);
    return {32'hD57A_0000, 32'((tag << 8) | r)};
  endfunction

  function automatic logic [63:0] mk_src(input int r, input int tag);
    return {32'h5C5C_0000, 32'((tag << 8) | r)};
  endfunction

  function automatic logic [255:0] mk_data(input int r, input int tag);
    logic [31:0] w;
    w = 32'(tag * 16 + r) ^ 32'hA5A5_0000;
    return {8{w}};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] e, input int tag);
    umi_in_valid = v;
    for (int r = 0; r < N; r++) begin
      umi_in_cmd[r*CW +: CW]     = mk_cmd(r, tag, e[r]);
      umi_in_dstaddr[r*AW +: AW] = mk_dst(r, tag);
      umi_in_srcaddr[r*AW +: AW] = mk_src(r, tag);
      umi_in_data[r*DW +: DW]    = mk_data(r, tag);
    end
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input int r, input int tag, input logic eom);
    chk({name, " cmd"},  umi_out_cmd,     mk_cmd(r, tag, eom));
    chk({name, " dst"},  umi_out_dstaddr, mk_dst(r, tag));
    chk({name, " src"},  umi_out_srcaddr, mk_src(r, tag));
    chk({name, " data"}, umi_out_data,    mk_data(r, tag));
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] eom;
    logic       oready;
    logic [3:0] exp_ready;
    logic       exp_ovalid;
    logic [1:0] exp_srcid;
    logic [1:0] exp_ptr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // valid, eom, oready, exp_ready, exp_ovalid, exp_srcid, exp_ptr
    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd3};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd0};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1};
    vecs[5]  = '{4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[6]  = '{4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[7]  = '{4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[8]  = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd3};
    vecs[9]  = '{4'b1001, 4'b0001, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd0};
    vecs[10] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd0};
    vecs[11] = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd0};
    vecs[12] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd0};
    vecs[13] = '{4'b0110, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2};
    vecs[14] = '{4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1};

    nreset        = 1'b0;
    umi_out_ready = 1'b1;
    drive(4'b0000, 4'b1111, 0);

    // Reset: ready must stay low even with every requester valid.
    @(negedge clk);
    drive(4'b1111, 4'b1111, 0);
    #1;
    chk("reset ready", umi_in_ready, 4'b0000);
    @(posedge clk); #1;
    chk("reset out_valid", umi_out_valid, 1'b0);
    chk("reset srcid", umi_out_srcid, 2'd0);
    chk("reset cmd", umi_out_cmd, 32'd0);
    chk("reset ptr", dut.rr_ptr_q, 2'd0);
    chk("reset state", dut.state_q, ARB_IDLE);

    // Idle for 10 cycles after reset release.
    @(negedge clk);
    nreset = 1'b1;
    drive(4'b0000, 4'b1111, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("idle%0d ready", c), umi_in_ready, 4'b0000);
      chk($sformatf("idle%0d out_valid", c), umi_out_valid, 1'b0);
    end
    chk("idle ptr", dut.rr_ptr_q, 2'd0);

    // Table: rotation, packet lock, lock-holder gap, empty cycles, wrap.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].eom, i);
      umi_out_ready = vecs[i].oready;
      #1;
      chk($sformatf("v%0d ready", i), umi_in_ready, vecs[i].exp_ready);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), umi_out_valid, vecs[i].exp_ovalid);
      chk($sformatf("v%0d srcid", i), umi_out_srcid, vecs[i].exp_srcid);
      chk($sformatf("v%0d ptr", i), dut.rr_ptr_q, vecs[i].exp_ptr);
      if (vecs[i].exp_ovalid)
        chk_beat($sformatf("v%0d", i), int'(vecs[i].exp_srcid), i,
                 vecs[i].eom[vecs[i].exp_srcid]);
    end

    // Backpressure: output holds beat (req0, tag 14) for 5 stalled cycles.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(4'b1111, 4'b1111, 20);
      umi_out_ready = 1'b0;
      #1;
      chk($sformatf("stall%0d ready", c), umi_in_ready, 4'b0000);
      @(posedge clk); #1;
      chk($sformatf("stall%0d out_valid", c), umi_out_valid, 1'b1);
      chk($sformatf("stall%0d srcid", c), umi_out_srcid, 2'd0);
      chk_beat($sformatf("stall%0d", c), 0, 14, 1'b1);
    end
    @(negedge clk);
    umi_out_ready = 1'b1;
    #1;
    chk("release ready", umi_in_ready, 4'b0010);
    @(posedge clk); #1;
    chk("release out_valid", umi_out_valid, 1'b1);
    chk("release srcid", umi_out_srcid, 2'd1);
    chk_beat("release", 1, 20, 1'b1);
    chk("release ptr", dut.rr_ptr_q, 2'd2);

    // Reset in the middle of a 4-beat packet from req2.
    @(negedge clk);
    drive(4'b0100, 4'b0000, 30);
    #1;
    chk("pkt2 b1 ready", umi_in_ready, 4'b0100);
    @(posedge clk); #1;
    chk("pkt2 b1 srcid", umi_out_srcid, 2'd2);
    chk("pkt2 b1 state", dut.state_q, ARB_LOCKED);
    chk("pkt2 b1 ptr", dut.rr_ptr_q, 2'd3);
    @(negedge clk);
    nreset = 1'b0;
    drive(4'b0101, 4'b0000, 31);
    #1;
    chk("midrst ready", umi_in_ready, 4'b0000);
    @(posedge clk); #1;
    chk("midrst state", dut.state_q, ARB_IDLE);
    chk("midrst ptr", dut.rr_ptr_q, 2'd0);
    chk("midrst out_valid", umi_out_valid, 1'b0);
    chk("midrst srcid", umi_out_srcid, 2'd0);
    @(negedge clk);
    nreset = 1'b1;
    drive(4'b0101, 4'b1111, 32);
    #1;
    chk("postrst ready", umi_in_ready, 4'b0001);
    @(posedge clk); #1;
    chk("postrst out_valid", umi_out_valid, 1'b1);
    chk("postrst srcid", umi_out_srcid, 2'd0);
    chk_beat("postrst", 0, 32, 1'b1);
    chk("postrst state", dut.state_q, ARB_IDLE);
    chk("postrst ptr", dut.rr_ptr_q, 2'd1);

`ifdef UMI_RR_ARBITER_STATS_EN
    // Counters: clear, then 7 beats from req3 and 2 from req0.
    @(negedge clk);
    nreset = 1'b0;
    drive(4'b0000, 4'b1111, 40);
    @(negedge clk);
    nreset = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(4'b1000, 4'b1111, 41 + c);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(4'b0001, 4'b1111, 50 + c);
    end
    @(negedge clk);
    drive(4'b0000, 4'b1111, 60);
    @(negedge clk); #1;
    chk("stat req0", stat_beats[0 +: 32], 32'd2);
    chk("stat req1", stat_beats[32 +: 32], 32'd0);
    chk("stat req2", stat_beats[64 +: 32], 32'd0);
    chk("stat req3", stat_beats[96 +: 32], 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
